// File: rtl/sat_accum_pkg.sv
// Shared types and saturation limits for the saturating frame accumulator.
package sat_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Largest positive two's complement value representable in `width` bits.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Most negative two's complement value representable in `width` bits.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/signed_sat_add.sv
// Combinational signed saturating adder: clamps to MAX/MIN on two's complement overflow.
module signed_sat_add
  import sat_accum_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

  logic [WIDTH-1:0] raw;

  assign raw = a + b;
  // Overflow only when both operands share a sign and the wrapped result flips it.
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
  assign sum = ovf ? (a[WIDTH-1] ? MIN_V : MAX_V) : raw;

endmodule

// File: rtl/sat_accum_sequencer.sv
// Frame sequencer: accumulates N signed samples with per-add saturation and emits one sum per frame.
// Optional per-frame saturation counter on port sat_cnt when SAT_ACCUM_SAT_CNT_EN is defined.
module sat_accum_sequencer
  import sat_accum_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
`ifdef SAT_ACCUM_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0] sat_cnt
`endif
);

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sat, sat_d;
  logic             beat;
  logic [WIDTH-1:0] add_a, add_sum;
  logic             add_ovf;
`ifdef SAT_ACCUM_SAT_CNT_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
`endif

  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign out_data  = acc;
  assign out_sat   = sat;
  assign beat      = in_valid && in_ready;

  // The first beat of a frame adds to zero so a stale acc never leaks into a new frame.
  assign add_a = (state == IDLE) ? '0 : acc;

  signed_sat_add #(.WIDTH(WIDTH)) u_add (
    .a   (add_a),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // NOTE: every next-state variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    sat_d   = sat;
`ifdef SAT_ACCUM_SAT_CNT_EN
    sat_cnt_d = sat_cnt_q;
`endif
    case (state)
      IDLE: begin
        if (beat) begin
          acc_d   = add_sum;
          cnt_d   = CNT_W'(1);
          sat_d   = 1'b0;
`ifdef SAT_ACCUM_SAT_CNT_EN
          sat_cnt_d = CNT_W'(add_ovf);
`endif
          state_d = (N == 1) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          cnt_d = cnt + 1'b1;
          sat_d = sat | add_ovf;
`ifdef SAT_ACCUM_SAT_CNT_EN
          if (add_ovf && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
`endif
          if (cnt == CNT_W'(N - 1)) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
`ifdef SAT_ACCUM_SAT_CNT_EN
      sat_cnt_q <= '0;
`endif
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      sat   <= sat_d;
`ifdef SAT_ACCUM_SAT_CNT_EN
      sat_cnt_q <= sat_cnt_d;
`endif
    end
  end

`ifdef SAT_ACCUM_SAT_CNT_EN
  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sat_accum_sequencer.sv
// Self-checking bench for sat_accum_sequencer (N=4 and N=1 instances) against a clamped-integer model.
module tb_sat_accum_sequencer;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int CNT_W = $clog2(N + 1);
  localparam int MAXV  = 7;
  localparam int MINV  = -8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [WIDTH-1:0] in_data, out_data;
  logic             d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_out_sat;
  logic [WIDTH-1:0] d1_in_data, d1_out_data;
`ifdef SAT_ACCUM_SAT_CNT_EN
  logic [CNT_W-1:0] sat_cnt;
  logic [0:0]       d1_sat_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  sat_accum_sequencer #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef SAT_ACCUM_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  sat_accum_sequencer #(.WIDTH(WIDTH), .N(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
    .in_data   (d1_in_data),
    .out_valid (d1_out_valid),
    .out_ready (d1_out_ready),
    .out_data  (d1_out_data),
    .out_sat   (d1_out_sat)
`ifdef SAT_ACCUM_SAT_CNT_EN
    ,
    .sat_cnt   (d1_sat_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: frame sum with clamping after every addition, plain integer arithmetic.
  function automatic void model(input int q[$], output int sum, output int sat, output int nsat);
    int acc;
    acc  = 0;
    sat  = 0;
    nsat = 0;
    foreach (q[i]) begin
      int t;
      t = acc + q[i];
      if (t > MAXV) begin
        t = MAXV; sat = 1; nsat++;
      end else if (t < MINV) begin
        t = MINV; sat = 1; nsat++;
      end
      acc = t;
    end
    if (nsat > (1 << CNT_W) - 1) nsat = (1 << CNT_W) - 1;
    sum = acc;
  endfunction

  task automatic send(input int x, input int gap);
    int g;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = WIDTH'(x);
    g = 0;
    while (!in_ready && g < 20) begin
      tick();
      g++;
    end
    check("in_ready_for_beat", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int q[$], input int stall);
    int sum, sat, nsat, g;
    model(q, sum, sat, nsat);
    g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    check({tag, "/out_valid"}, out_valid, 1);
    repeat (stall) tick();
    check({tag, "/data"}, $signed(out_data), sum);
    check({tag, "/sat"}, out_sat, sat);
`ifdef SAT_ACCUM_SAT_CNT_EN
    check({tag, "/sat_cnt"}, sat_cnt, nsat);
`endif
    check({tag, "/in_ready_low"}, in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "/valid_drop"}, out_valid, 0);
    check({tag, "/ready_back"}, in_ready, 1);
  endtask

  task automatic run_frame(input string tag, input int q[$], input int maxgap, input int stall);
    foreach (q[i]) send(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    expect_frame(tag, q, stall);
  endtask

  initial begin
    int q[$];
    int g;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    d1_in_valid  = 1'b0;
    d1_in_data   = '0;
    d1_out_ready = 1'b0;
    repeat (2) tick();
    check("rst/in_ready", in_ready, 1);
    check("rst/out_valid", out_valid, 0);
    check("rst/out_data", $signed(out_data), 0);
    check("rst/out_sat", out_sat, 0);
    rst_n = 1'b1;
    tick();

    // Plain frame plus latency: out_valid must rise right after beat 4.
    send(1, 0); send(2, 0); send(3, 0);
    check("lat/before_last", out_valid, 0);
    send(-1, 0);
    check("lat/after_last", out_valid, 1);
    q = {1, 2, 3, -1};
    expect_frame("plain", q, 0);

    q = {7, 7, -8, 0};
    run_frame("sat_pos", q, 0, 0);
    q = {-8, -8, -8, -8};
    run_frame("sat_neg", q, 0, 0);
    q = {7, -8, 0, 0};
    run_frame("max_plus_min", q, 0, 0);
    q = {-8, 0, 0, 0};
    run_frame("min_plus_zero", q, 0, 0);

    // Output stall with a beat offered that must not be taken.
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    in_valid = 1'b1;
    in_data  = 4'd7;
    repeat (3) begin
      tick();
      check("stall/out_valid", out_valid, 1);
      check("stall/data", $signed(out_data), 4);
      check("stall/in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    q = {1, 1, 1, 1};
    expect_frame("stall", q, 0);
    q = {1, 2, 1, 2};
    run_frame("after_stall", q, 0, 0);

    // Mid-frame reset abandons the partial frame.
    send(5, 0); send(5, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst/in_ready", in_ready, 1);
    check("midrst/out_valid", out_valid, 0);
    check("midrst/out_data", $signed(out_data), 0);
    check("midrst/out_sat", out_sat, 0);
`ifdef SAT_ACCUM_SAT_CNT_EN
    check("midrst/sat_cnt", sat_cnt, 0);
`endif
    q = {1, 1, 1, 1};
    run_frame("post_rst", q, 0, 0);

    // Randomized frames with input gaps and output stalls.
    for (int f = 0; f < 30; f++) begin
      q = {};
      for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(0, 15)) - 8);
      run_frame($sformatf("rand%0d", f), q, 2, int'($urandom_range(0, 3)));
    end

    // N=1 instance: each beat is a whole frame.
    d1_in_valid = 1'b1;
    d1_in_data  = WIDTH'(-3);
    tick();
    d1_in_valid = 1'b0;
    check("n1/a_valid", d1_out_valid, 1);
    check("n1/a_data", $signed(d1_out_data), -3);
    check("n1/a_sat", d1_out_sat, 0);
`ifdef SAT_ACCUM_SAT_CNT_EN
    check("n1/a_sat_cnt", d1_sat_cnt, 0);
`endif
    d1_out_ready = 1'b1;
    tick();
    d1_out_ready = 1'b0;
    repeat (2) tick();
    check("n1/gap_ready", d1_in_ready, 1);
    check("n1/gap_valid", d1_out_valid, 0);
    d1_in_valid = 1'b1;
    d1_in_data  = WIDTH'(6);
    tick();
    d1_in_valid = 1'b0;
    g = 0;
    while (!d1_out_valid && g < 20) begin
      tick();
      g++;
    end
    check("n1/b_valid", d1_out_valid, 1);
    check("n1/b_data", $signed(d1_out_data), 6);
    check("n1/b_sat", d1_out_sat, 0);
    d1_out_ready = 1'b1;
    tick();
    d1_out_ready = 1'b0;
    check("n1/b_done", d1_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
